mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle RV32I control sequencer: Moore FSM plus combinational ALU/immediate decode that steps a shared
//  datapath through fetch/decode/execute/writeback. Drives one ALU, one unified memory port, IR/PC/regfile enables.
//  Supports lw, sw, R-type, I-type ALU, beq, jal. Sits beside the multicycle datapath at top level.
// PARAMETERS
//  HAS_MEM_READY  1  1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
//  STATE_W        4  state register width (11 states used)
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  synchronous, active-high reset
//  op          in   7  instr[6:0] from IR
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  Zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes current access this cycle
//  mem_valid   out  1  memory access requested (FETCH, MEMREAD, MEMWRITE)
//  AdrSrc      out  1  0: PC, 1: ALUOut as memory address
//  MemWrite    out  1  store request; held until mem_ready
//  IRWrite     out  1  load IR (and OldPC)
//  PCWrite     out  1  PC load enable = PCUpdate | (Branch & Zero)
//  RegWrite    out  1  regfile write enable
//  ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA     out  2  00 PC, 01 OldPC, 10 RD1
//  ALUSrcB     out  2  00 RD2, 01 ImmExt, 10 const 4
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc      out  2  00 I, 01 S, 10 B, 11 J; comb from op (lw/I 00, sw 01, beq 10, jal 11, else 00)
//  retire      out  1  1-cycle pulse in last cycle of each instruction
//  illegal_op  out  1  1-cycle pulse in DECODE when op unsupported
// BEHAVIOUR
//  - Reset: state<=FETCH; while reset=1, PCWrite/IRWrite/MemWrite/RegWrite/mem_valid/retire/illegal_op forced 0,
//    other outputs per FETCH decode. Reset mid-instruction abandons it; first cycle after reset is FETCH.
//  - Outputs are Moore (state only) except PCWrite/IRWrite/MemWrite/retire (qualified by Zero/mem_ready) and ImmSrc/ALUControl.
//  - ALUOp: 00 add, 01 sub, 10 funct. Funct decode: funct3 000 -> sub iff op[5]&funct7b5 else add; 010 slt; 110 or;
//    111 and; other funct3 -> add.
//  - FETCH: mem_valid=1, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay until mem_ready -> DECODE.
//  - DECODE: A=01, B=01, ALUOp=00 (branch target into ALUOut). Next by op: 0000011/0100011->MEMADR, 0110011->EXECR,
//    0010011->EXECI, 1100011->BEQ, 1101111->JAL; other -> FETCH, illegal_op=1, no architectural write.
//  - MEMADR: A=10, B=01, ALUOp=00 -> MEMREAD if op[5]=0 else MEMWRITE.
//  - MEMREAD: mem_valid=1, AdrSrc=1, ResultSrc=00; stay until mem_ready -> MEMWB.
//  - MEMWB: ResultSrc=01, RegWrite=1, retire=1 -> FETCH.
//  - MEMWRITE: mem_valid=1, AdrSrc=1, MemWrite=1 every wait cycle; on mem_ready retire=1 -> FETCH.
//  - EXECR: A=10, B=00, ALUOp=10; EXECI: A=10, B=01, ALUOp=10; both -> ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite=1, retire=1 -> FETCH.
//  - BEQ: A=10, B=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, retire=1 -> FETCH.
//  - JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= PC+4).
//  - Unused state encodings -> FETCH next cycle, all enables 0. Latency (ready=1): lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
// STRUCTURE
//  - Shared package/defines: state encodings, opcode constants, ALUOp, ALUControl, ImmSrc, ResultSrc/ALUSrc codes.
//  - One sub-module: mc_alu_decode (comb: op5, funct3, funct7b5, ALUOp -> ALUControl). FSM and output decode stay here.
// TESTING
//  - lw x5,8(x1), mem_ready=0 for 2 cycles in FETCH and MEMREAD -> FETCHx3,DECODE,MEMADR,MEMREADx3,MEMWB; one retire.
//  - sub (0110011,f3=000,f7b5=1) -> EXECR ALUControl=001; ALUWB RegWrite=1; 4 cycles, retire once.
//  - beq Zero=1 then Zero=0 -> BEQ PCWrite=1 then 0; ALUControl=001; 3 cycles each.
//  - sw, mem_ready low 3 cycles -> MemWrite=1 & AdrSrc=1 for 4 cycles, retire on ready cycle only, RegWrite never 1.
//  - op=0000000 -> DECODE illegal_op=1, back to FETCH, no RegWrite/MemWrite/PCWrite beyond fetch.
//  - reset=1 during MEMWRITE wait -> MemWrite=0 same cycle; after release state FETCH, mem_valid=1, AdrSrc=0.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package mc_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Immediate format follows the opcode alone, independent of FSM state.
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      logic [1:0] imm;
      imm = IMM_I;
      case (op)
         OP_STORE:  imm = IMM_S;
         OP_BRANCH: imm = IMM_B;
         OP_JAL:    imm = IMM_J;
         default:   imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle sequencer (master) and the datapath /
// unified memory port (slave).
interface mc_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       mem_ready;

   logic       mem_valid;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] ImmSrc;
   logic       retire;
   logic       illegal_op;

   modport master (
      input  op, funct3, funct7b5, Zero, mem_ready,
      output mem_valid, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, retire, illegal_op
   );

   modport slave (
      output op, funct3, funct7b5, Zero, mem_ready,
      input  mem_valid, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, retire, illegal_op
   );
endinterface

// File: rtl/mc_alu_decode.sv
// ALU operation decode: maps the FSM's ALUOp plus instruction function bits
// onto the ALU control code.
module mc_alu_decode
   import mc_controller_pkg::*;
(
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [1:0] alu_op,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // addi has no sub form, so funct7b5 only matters for R-type
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control sequencer: Moore FSM stepping a shared datapath
// through fetch / decode / execute / writeback for lw, sw, R, I, beq, jal.
//
// state    | meaning
// FETCH    | read instruction at PC, IR/OldPC load and PC <= PC+4 on mem_ready
// DECODE   | read regfile, ALUOut <= OldPC + imm (branch/jump target)
// MEMADR   | ALUOut <= rs1 + imm
// MEMREAD  | load word at ALUOut, wait for mem_ready
// MEMWB    | rd <= Data
// MEMWRITE | store rs2 at ALUOut, wait for mem_ready
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BEQ      | rs1 - rs2, PC <= ALUOut when Zero
// JAL      | PC <= ALUOut, ALUOut <= OldPC + 4
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int          HAS_MEM_READY = 1,
   parameter int unsigned STATE_W       = 4
) (
   input logic             clk,
   input logic             reset,
   mc_controller_if.master bus
);

   localparam logic [STATE_W-1:0] ST_FETCH    = STATE_W'(S_FETCH);
   localparam logic [STATE_W-1:0] ST_DECODE   = STATE_W'(S_DECODE);
   localparam logic [STATE_W-1:0] ST_MEMADR   = STATE_W'(S_MEMADR);
   localparam logic [STATE_W-1:0] ST_MEMREAD  = STATE_W'(S_MEMREAD);
   localparam logic [STATE_W-1:0] ST_MEMWB    = STATE_W'(S_MEMWB);
   localparam logic [STATE_W-1:0] ST_MEMWRITE = STATE_W'(S_MEMWRITE);
   localparam logic [STATE_W-1:0] ST_EXECR    = STATE_W'(S_EXECR);
   localparam logic [STATE_W-1:0] ST_EXECI    = STATE_W'(S_EXECI);
   localparam logic [STATE_W-1:0] ST_ALUWB    = STATE_W'(S_ALUWB);
   localparam logic [STATE_W-1:0] ST_BEQ      = STATE_W'(S_BEQ);
   localparam logic [STATE_W-1:0] ST_JAL      = STATE_W'(S_JAL);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic [STATE_W-1:0] cur_state;

   logic       ready;
   logic       en;
   logic       mem_valid;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       pc_update;
   logic       branch;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] src_a;
   logic [1:0] src_b;
   logic [1:0] alu_op;
   logic       retire;
   logic       illegal;
   logic [2:0] alu_control;

   assign ready = (HAS_MEM_READY != 0) ? bus.mem_ready : 1'b1;
   assign en    = ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // While reset is held the mux selects show the FETCH decode so the
   // datapath sees a sane address path; enables are masked further down.
   assign cur_state = reset ? ST_FETCH : state_q;

   always_comb begin
      state_d    = ST_FETCH;
      mem_valid  = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      src_a      = SRCA_PC;
      src_b      = SRCB_RD2;
      alu_op     = ALUOP_ADD;
      retire     = 1'b0;
      illegal    = 1'b0;

      case (cur_state)
         ST_FETCH: begin
            mem_valid  = 1'b1;
            src_a      = SRCA_PC;
            src_b      = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = ready;
            pc_update  = ready;
            state_d    = ready ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            src_a = SRCA_OLDPC;
            src_b = SRCB_IMM;
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = ST_MEMADR;
               OP_RTYPE:          state_d = ST_EXECR;
               OP_ITYPE:          state_d = ST_EXECI;
               OP_BRANCH:         state_d = ST_BEQ;
               OP_JAL:            state_d = ST_JAL;
               default: begin
                  illegal = 1'b1;
                  state_d = ST_FETCH;
               end
            endcase
         end
         ST_MEMADR: begin
            src_a   = SRCA_RD1;
            src_b   = SRCB_IMM;
            state_d = bus.op[5] ? ST_MEMWRITE : ST_MEMREAD;
         end
         ST_MEMREAD: begin
            mem_valid  = 1'b1;
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            state_d    = ready ? ST_MEMWB : ST_MEMREAD;
         end
         ST_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_MEMWRITE: begin
            mem_valid = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
            retire    = ready;
            state_d   = ready ? ST_FETCH : ST_MEMWRITE;
         end
         ST_EXECR: begin
            src_a   = SRCA_RD1;
            src_b   = SRCB_RD2;
            alu_op  = ALUOP_FUNCT;
            state_d = ST_ALUWB;
         end
         ST_EXECI: begin
            src_a   = SRCA_RD1;
            src_b   = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = ST_ALUWB;
         end
         ST_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_BEQ: begin
            src_a      = SRCA_RD1;
            src_b      = SRCB_RD2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            branch     = 1'b1;
            retire     = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_JAL: begin
            // PC takes the target held in ALUOut while the ALU forms the link
            src_a      = SRCA_OLDPC;
            src_b      = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALUOUT;
            pc_update  = 1'b1;
            state_d    = ST_ALUWB;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   mc_alu_decode u_alu_decode (
      .op5         (bus.op[5]),
      .funct3      (bus.funct3),
      .funct7b5    (bus.funct7b5),
      .alu_op      (alu_op),
      .alu_control (alu_control)
   );

   assign bus.mem_valid  = en & mem_valid;
   assign bus.AdrSrc     = adr_src;
   assign bus.MemWrite   = en & mem_write;
   assign bus.IRWrite    = en & ir_write;
   assign bus.PCWrite    = en & (pc_update | (branch & bus.Zero));
   assign bus.RegWrite   = en & reg_write;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ALUControl = alu_control;
   assign bus.ImmSrc     = imm_src_of(bus.op);
   assign bus.retire     = en & retire;
   assign bus.illegal_op = en & illegal;

endmodule
